axis_s: RTL
===========

Name: axis_s

Overview:
Simple AXI-Stream slave, the receive end of the axis_m link. Accepts 32-bit beats on the AXIS interface into an internal synchronous FIFO and presents them to local logic through a registered read port. Reports per-packet beat count and completion on tlast. Backpressure via tready when the FIFO is full.

Parameters:
DEPTH, 8, FIFO depth in beats; power of two, >= 2
AW, 3, address width = log2(DEPTH)
LENW, 16, width of packet-length counter

Ports:
aclk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
tvalid  in  1  AXIS master has valid beat
tready  out  1  slave can accept beat
tdata  in  32  AXIS data
tlast  in  1  last beat of packet
rd_en  in  1  local read request
rd_data  out  32  data of read beat
rd_last  out  1  tlast flag stored with that beat
rd_valid  out  1  rd_data/rd_last valid this cycle
empty  out  1  FIFO holds no beats
full  out  1  FIFO holds DEPTH beats
level  out  AW+1  beats currently stored, 0..DEPTH
pkt_done  out  1  one-cycle pulse: packet completed on input side
pkt_len  out  LENW  beat count of most recently completed packet
underflow  out  1  sticky: rd_en seen while empty

Behaviour:
- Reset (rst=1 at edge): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_last=0, pkt_done=0, pkt_len=0, beat counter=0, underflow=0. Reset mid-packet discards FIFO contents and partial count; no pkt_done is produced for the aborted packet.
- tready = ~full, combinational from registered level; low during rst-driven state only via full=0 -> tready=1 after reset.
- Handshake hs = tvalid & tready. On hs: mem[wr_ptr] <= {tlast,tdata}; wr_ptr wraps mod DEPTH.
- Read: rd = rd_en & ~empty. On rd: {rd_last,rd_data} <= mem[rd_ptr], rd_ptr wraps mod DEPTH; rd_valid=1 next cycle (1-cycle latency). When rd=0: rd_valid<=0, rd_data/rd_last hold last value.
- rd_en while empty: no pointer change, rd_valid<=0, underflow<=1 (cleared only by rst).
- level: +1 on hs only, -1 on rd only, unchanged on both or neither. empty=(level==0), full=(level==DEPTH), both registered-derived.
- Simultaneous hs and rd when empty: write occurs, read ignored (empty), level->1.
- Simultaneous hs and rd when 0<level<DEPTH: both occur, level unchanged.
- When full: tready=0, no write; a rd that cycle frees a slot, tready=1 next cycle (no same-cycle bypass).
- Beat counter cnt (LENW): on hs with tlast=0, cnt<=cnt+1 saturating at 2^LENW-1. On hs with tlast=1: pkt_len<=cnt+1 (saturating), cnt<=0, pkt_done<=1 for exactly one cycle. pkt_done=0 otherwise.
- Single-beat packet (tlast on first beat): pkt_len=1.
- tdata/tlast ignored when hs=0; slave never drops an accepted beat.

Test Plan:
- Reset then send 3 beats 0xA1,0xA2,0xA3 (tlast on 3rd), rd_en low -> level=3, pkt_done one pulse the cycle after 3rd hs, pkt_len=3, tready stays 1.
- Fill: 8 beats 0x10..0x17 with rd_en low -> full=1, tready=0 after 8th hs; 9th beat held by master until one rd_en, then accepted one cycle later; readback order 0x10..0x18.
- Read latency: level=2, pulse rd_en one cycle -> rd_valid=1 next cycle with first beat data, rd_valid=0 following cycle, level=1.
- Concurrent: level=4, tvalid and rd_en high 10 cycles -> level stays 4, data in order, pointers wrap without corruption.
- Empty read: rd_en=1 with level=0 -> rd_valid=0, underflow=1 and remains 1 until rst; simultaneous hs with rd_en at empty -> level=1.
- Reset mid-packet: 2 beats no tlast, rst, then 1 beat with tlast -> pkt_len=1, level=1, single pkt_done pulse.

Source files
------------

// File: rtl/axis_s.sv
// AXI-Stream receive slave: buffers beats in a FIFO, exposes a registered
// read port, and reports per-packet beat counts on tlast.
module axis_s #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int LENW  = 16
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            tvalid,
  output logic            tready,
  input  logic [31:0]     tdata,
  input  logic            tlast,
  input  logic            rd_en,
  output logic [31:0]     rd_data,
  output logic            rd_last,
  output logic            rd_valid,
  output logic            empty,
  output logic            full,
  output logic [AW:0]     level,
  output logic            pkt_done,
  output logic [LENW-1:0] pkt_len,
  output logic            underflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [LENW-1:0] CNT_MAX = '1;

  logic [32:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LENW-1:0] cnt;
  logic [LENW-1:0] cnt_inc;
  logic            hs;
  logic            rd;

  assign empty  = (level == '0);
  assign full   = (level == FULL_LVL);
  assign tready = ~full;
  assign hs     = tvalid & tready;
  assign rd     = rd_en & ~empty;

  // beat count including the current beat, pinned at the top value
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge aclk) begin
    if (hs) mem[wr_ptr] <= {tlast, tdata};
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_len   <= '0;
      cnt       <= '0;
      underflow <= 1'b0;
    end else begin
      if (hs) wr_ptr <= wr_ptr + 1'b1;
      if (rd) begin
        rd_ptr             <= rd_ptr + 1'b1;
        {rd_last, rd_data} <= mem[rd_ptr];
      end
      rd_valid <= rd;
      if (rd_en && empty) underflow <= 1'b1;
      case ({hs, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      pkt_done <= hs & tlast;
      if (hs) begin
        if (tlast) begin
          pkt_len <= cnt_inc;
          cnt     <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule
